nanorv32_gpio_bridge: RTL and testbench
=======================================

Name: nanorv32_gpio_bridge

Overview:
- Upstream bridge between the CPU peripheral data port and the GPIO controller's bus_gpio_* slave interface.
- Registers each CPU request, drives one strobed access to the GPIO slave and waits for the slave's one-cycle-early ready (gpio_bus_ready_nxt).
- Returns read data, a ready pulse and an error flag to the CPU.
- A bounded-wait counter terminates accesses to a slave that never answers.

Parameters:
- ADDR_W, 12, width of the peripheral address (bits ADDR_W-1:0 passed to slave).
- TIMEOUT, 16, max ACCESS cycles before forced error completion; 0 disables timeout.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1); name kept for codebase consistency.
- cpu_periph_req  in  1  CPU request valid; held high until periph_cpu_ready=1 inclusive.
- cpu_periph_addr  in  ADDR_W  request address.
- cpu_periph_bytesel  in  4  byte lanes; nonzero = write, 0000 = read.
- cpu_periph_din  in  32  write data.
- periph_cpu_dout  out  32  read data, valid only while periph_cpu_ready=1.
- periph_cpu_ready  out  1  one-cycle completion pulse.
- periph_cpu_err  out  1  qualifies ready; 1 = timed out.
- bus_gpio_addr  out  ADDR_W  registered address to GPIO slave.
- bus_gpio_bytesel  out  4  registered byte lanes.
- bus_gpio_din  out  32  registered write data.
- bus_gpio_en  out  1  slave access strobe.
- gpio_bus_dout  in  32  slave read data, valid the cycle after gpio_bus_ready_nxt.
- gpio_bus_ready_nxt  in  1  slave completes next cycle.

Behaviour:
- Reset (async, rst_n=1): state=IDLE, addr/bytesel/din registers=0, counter=0, err_r=0.
  - All outputs 0: bus_gpio_en, periph_cpu_ready, periph_cpu_err, periph_cpu_dout, bus_gpio_*.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - cpu_periph_req=1: capture addr/bytesel/din, clear counter, err_r=0, next=ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - bus_gpio_en=1; bus_gpio_* driven from the captured registers, stable for the whole state.
  - gpio_bus_ready_nxt=1: next=RESP, err_r=0.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: next=RESP, err_r=1.
  - Else counter+1.
  - If ready_nxt and the timeout condition coincide, ready_nxt wins (err=0).
- RESP:
  - bus_gpio_en=0; periph_cpu_ready=1; periph_cpu_err=err_r; next=IDLE unconditionally.
  - periph_cpu_dout = gpio_bus_dout when the access was a read and err_r=0; otherwise 32'h0.
- Latency: req in IDLE at cycle N gives en in N+1. Slave answering immediately (ready_nxt in N+1) gives ready at N+2.
- Throughput: at most one transaction per 3 cycles.
- cpu_periph_req is ignored in ACCESS and RESP; the request fields are not re-sampled.
- req=1 in the IDLE cycle after RESP is a new transaction; back-to-back is legal.
- Writes complete identically to reads; no write data is returned (dout=0).
- bus_gpio_bytesel and bus_gpio_din retain their last values in IDLE/RESP; only en qualifies them.
- Reset mid-transaction: the FSM returns to IDLE immediately.
  - A ready pulse is never emitted for the aborted access.
  - en drops asynchronously.
- gpio_bus_ready_nxt outside ACCESS is ignored.

Test Plan:
- Read: addr=0x004, bytesel=0000, req=1 at cycle 0; slave returns ready_nxt in cycle 1 and dout=0xA5A5_0001 in cycle 2 -> en=1 in cycle 1 only, ready=1/err=0/dout=0xA5A5_0001 in cycle 2.
- Write: bytesel=1111, din=0xDEAD_BEEF -> bus_gpio_din=0xDEAD_BEEF with en=1 until ready_nxt; ready=1 with dout=0 one cycle after ready_nxt.
- Wait states: slave withholds ready_nxt for 5 ACCESS cycles -> en held 6 cycles, addr/din stable throughout, single ready pulse.
- Timeout: TIMEOUT=16, slave never answers -> en high for exactly 16 cycles, then ready=1, err=1, dout=0. Repeat with ready_nxt on cycle 16 -> err=0.
- Back-to-back: req held continuously across three reads -> en pulses start at cycles 1, 4 and 7; exactly three ready pulses.
- Reset mid-ACCESS: assert rst_n=1 during cycle 2 of a waited access -> en=0 immediately, no ready pulse, and the next request behaves as from reset.

Source files
------------

// File: rtl/nanorv32_gpio_bridge.sv
// CPU peripheral port to GPIO slave bridge: registers one request, strobes the slave
// until it signals ready (or the bounded wait expires) and returns a one-cycle response.
module nanorv32_gpio_bridge #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_periph_req,
    input  logic [ADDR_W-1:0] cpu_periph_addr,
    input  logic [3:0]        cpu_periph_bytesel,
    input  logic [31:0]       cpu_periph_din,
    output logic [31:0]       periph_cpu_dout,
    output logic              periph_cpu_ready,
    output logic              periph_cpu_err,
    output logic [ADDR_W-1:0] bus_gpio_addr,
    output logic [3:0]        bus_gpio_bytesel,
    output logic [31:0]       bus_gpio_din,
    output logic              bus_gpio_en,
    input  logic [31:0]       gpio_bus_dout,
    input  logic              gpio_bus_ready_nxt
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        bytesel_q, bytesel_d;
    logic [31:0]       din_q, din_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            bytesel_q <= '0;
            din_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            bytesel_q <= bytesel_d;
            din_q     <= din_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        bytesel_d = bytesel_q;
        din_d     = din_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (cpu_periph_req) begin
                    addr_d    = cpu_periph_addr;
                    bytesel_d = cpu_periph_bytesel;
                    din_d     = cpu_periph_din;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                // A slave answer in the final allowed cycle still beats the timeout.
                if (gpio_bus_ready_nxt) begin
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus_gpio_en      = (state_q == StAccess);
    assign bus_gpio_addr    = addr_q;
    assign bus_gpio_bytesel = bytesel_q;
    assign bus_gpio_din     = din_q;
    assign periph_cpu_ready = (state_q == StResp);
    assign periph_cpu_err   = periph_cpu_ready & err_q;
    assign periph_cpu_dout  = (periph_cpu_ready && (bytesel_q == 4'b0000) && !err_q)
                              ? gpio_bus_dout : 32'h0;

endmodule

// File: tb/tb_nanorv32_gpio_bridge.sv
// Randomized self-checking bench for nanorv32_gpio_bridge with a transaction-level
// reference model (enable length, error and returned data computed from wait count).
module tb_nanorv32_gpio_bridge;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic              clk;
    logic              rst_n;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        bytesel;
    logic [31:0]       din;
    logic [31:0]       periph_cpu_dout;
    logic              periph_cpu_ready;
    logic              periph_cpu_err;
    logic [ADDR_W-1:0] bus_gpio_addr;
    logic [3:0]        bus_gpio_bytesel;
    logic [31:0]       bus_gpio_din;
    logic              bus_gpio_en;
    logic [31:0]       gpio_dout;
    logic              ready_nxt;

    int n_checks;
    int n_fail;

    nanorv32_gpio_bridge #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cpu_periph_req    (req),
        .cpu_periph_addr   (addr),
        .cpu_periph_bytesel(bytesel),
        .cpu_periph_din    (din),
        .periph_cpu_dout   (periph_cpu_dout),
        .periph_cpu_ready  (periph_cpu_ready),
        .periph_cpu_err    (periph_cpu_err),
        .bus_gpio_addr     (bus_gpio_addr),
        .bus_gpio_bytesel  (bus_gpio_bytesel),
        .bus_gpio_din      (bus_gpio_din),
        .bus_gpio_en       (bus_gpio_en),
        .gpio_bus_dout     (gpio_dout),
        .gpio_bus_ready_nxt(ready_nxt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_all_zero(input string name);
        n_checks++;
        if (bus_gpio_en !== 1'b0 || periph_cpu_ready !== 1'b0 || periph_cpu_err !== 1'b0 ||
            periph_cpu_dout !== 32'h0 || bus_gpio_addr !== '0 || bus_gpio_bytesel !== 4'h0 ||
            bus_gpio_din !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: en=%b rdy=%b err=%b dout=%h addr=%h bs=%h din=%h, all must be 0",
                     name, bus_gpio_en, periph_cpu_ready, periph_cpu_err, periph_cpu_dout,
                     bus_gpio_addr, bus_gpio_bytesel, bus_gpio_din);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = 1'b0; addr = '0; bytesel = '0; din = '0;
        gpio_dout = 32'h1234_5678; ready_nxt = 1'b0;
        #1;
        check_all_zero("reset_state");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
    endtask

    // One transaction; the slave asserts ready_nxt in ACCESS cycle index k (0-based).
    task automatic txn(input logic [ADDR_W-1:0] a, input logic [3:0] bs, input logic [31:0] d,
                       input logic [31:0] rdata, input int k, input string name);
        int exp_en, en_cnt, first_en, rdy_cyc, rdy_cnt, idx, bad_fields;
        bit exp_err, rn_prev, rdy_err;
        logic [31:0] exp_dout, rdy_dout;
        exp_err  = (TIMEOUT != 0) && (k >= TIMEOUT);
        exp_en   = exp_err ? TIMEOUT : k + 1;
        exp_dout = (bs == 4'b0000 && !exp_err) ? rdata : 32'h0;
        en_cnt = 0; first_en = -1; rdy_cyc = -1; rdy_cnt = 0; idx = 0; bad_fields = 0;
        rn_prev = 1'b0; rdy_err = 1'b0; rdy_dout = 32'h0;
        @(posedge clk); #1;
        req = 1'b1; addr = a; bytesel = bs; din = d; ready_nxt = 1'b0; gpio_dout = $urandom;
        for (int c = 1; c <= exp_en + 3; c++) begin
            @(posedge clk); #1;
            gpio_dout = rn_prev ? rdata : $urandom;
            rn_prev   = 1'b0;
            if (c == 1) begin
                addr = ADDR_W'($urandom); bytesel = 4'($urandom); din = $urandom;
            end
            if (bus_gpio_en) begin
                ready_nxt = (idx == k);
                rn_prev   = ready_nxt;
                idx++;
            end else begin
                ready_nxt = 1'($urandom_range(0, 1));
            end
            #1;
            if (bus_gpio_en) begin
                en_cnt++;
                if (first_en < 0) first_en = c;
                if (bus_gpio_addr !== a || bus_gpio_bytesel !== bs || bus_gpio_din !== d)
                    bad_fields++;
            end
            if (periph_cpu_ready) begin
                rdy_cnt++;
                rdy_cyc  = c;
                rdy_err  = periph_cpu_err;
                rdy_dout = periph_cpu_dout;
                req      = 1'b0;
            end else if (periph_cpu_err !== 1'b0) begin
                bad_fields++;
            end
        end
        req = 1'b0;
        n_checks++;
        if (en_cnt != exp_en) begin
            n_fail++; $display("FAIL %s en_cycles: got %0d expected %0d", name, en_cnt, exp_en);
        end
        n_checks++;
        if (first_en != 1) begin
            n_fail++; $display("FAIL %s en_latency: got %0d expected 1", name, first_en);
        end
        n_checks++;
        if (rdy_cnt != 1) begin
            n_fail++; $display("FAIL %s ready_pulses: got %0d expected 1", name, rdy_cnt);
        end
        n_checks++;
        if (rdy_cyc != exp_en + 1) begin
            n_fail++;
            $display("FAIL %s ready_cycle: got %0d expected %0d", name, rdy_cyc, exp_en + 1);
        end
        n_checks++;
        if (rdy_err !== exp_err) begin
            n_fail++; $display("FAIL %s err: got %b expected %b", name, rdy_err, exp_err);
        end
        n_checks++;
        if (rdy_dout !== exp_dout) begin
            n_fail++; $display("FAIL %s dout: got %h expected %h", name, rdy_dout, exp_dout);
        end
        n_checks++;
        if (bad_fields != 0) begin
            n_fail++; $display("FAIL %s bus_fields: %0d bad cycles, expected 0", name, bad_fields);
        end
        n_checks++;
        if (bus_gpio_din !== d || bus_gpio_bytesel !== bs) begin
            n_fail++;
            $display("FAIL %s retained: din=%h bs=%h expected din=%h bs=%h",
                     name, bus_gpio_din, bus_gpio_bytesel, d, bs);
        end
    endtask

    task automatic test_directed();
        txn(12'h004, 4'b0000, 32'h0, 32'hA5A5_0001, 0, "read");
        txn(12'h010, 4'b1111, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, "write");
        txn(12'h020, 4'b0000, 32'h0, 32'h0BAD_F00D, 5, "wait5");
        txn(12'h030, 4'b0000, 32'h0, 32'h1111_2222, 1000, "timeout");
        txn(12'h034, 4'b0000, 32'h0, 32'h3333_4444, TIMEOUT - 1, "ready_last_cycle");
        txn(12'h038, 4'b0011, 32'hCAFE_0001, 32'h7777_8888, TIMEOUT, "ready_too_late");
    endtask

    task automatic test_idle_noise();
        int bad;
        bad = 0;
        req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            ready_nxt = 1'($urandom_range(0, 1));
            gpio_dout = $urandom;
            #1;
            if (bus_gpio_en !== 1'b0 || periph_cpu_ready !== 1'b0 || periph_cpu_err !== 1'b0 ||
                periph_cpu_dout !== 32'h0)
                bad++;
        end
        ready_nxt = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL idle_noise: %0d active cycles, expected 0", bad);
        end
    endtask

    task automatic test_random();
        logic [3:0] bs;
        for (int i = 0; i < 24; i++) begin
            bs = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            txn(ADDR_W'($urandom), bs, $urandom, $urandom, int'($urandom_range(0, 20)), "random");
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd [3];
        int starts[$];
        int nrdy;
        bit prev_en, rn_prev;
        rd[0] = 32'h0000_00A1; rd[1] = 32'h0000_00B2; rd[2] = 32'h0000_00C3;
        nrdy = 0; prev_en = 1'b0; rn_prev = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; addr = 12'h100; bytesel = 4'b0000; din = 32'h0; ready_nxt = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            gpio_dout = (rn_prev && nrdy < 3) ? rd[nrdy] : $urandom;
            ready_nxt = bus_gpio_en;
            rn_prev   = bus_gpio_en;
            #1;
            if (bus_gpio_en && !prev_en) starts.push_back(c);
            prev_en = bus_gpio_en;
            if (periph_cpu_ready) begin
                n_checks++;
                if (nrdy >= 3 || periph_cpu_dout !== rd[nrdy % 3]) begin
                    n_fail++;
                    $display("FAIL b2b_dout[%0d]: got %h expected %h", nrdy, periph_cpu_dout,
                             rd[nrdy % 3]);
                end
                nrdy++;
                if (nrdy == 3) req = 1'b0;
            end
        end
        req = 1'b0; ready_nxt = 1'b0;
        n_checks++;
        if (nrdy != 3) begin
            n_fail++; $display("FAIL b2b_ready_count: got %0d expected 3", nrdy);
        end
        n_checks++;
        if (starts.size() != 3 || starts[0] != 1 || starts[1] != 4 || starts[2] != 7) begin
            n_fail++;
            $display("FAIL b2b_en_starts: got %p expected '{1, 4, 7}", starts);
        end
    endtask

    task automatic test_reset_mid_access();
        int saw_rdy;
        saw_rdy = 0;
        @(posedge clk); #1;
        req = 1'b1; addr = 12'h0AB; bytesel = 4'hF; din = 32'h0123_4567; ready_nxt = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (bus_gpio_en !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_pre_en: got %b expected 1", bus_gpio_en);
        end
        rst_n = 1'b1;
        req   = 1'b0;
        #1;
        n_checks++;
        if (bus_gpio_en !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_async_en: got %b expected 0", bus_gpio_en);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            ready_nxt = 1'b1;
            #1;
            if (periph_cpu_ready !== 1'b0) saw_rdy++;
        end
        rst_n = 1'b0;
        ready_nxt = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #2;
            if (periph_cpu_ready !== 1'b0) saw_rdy++;
        end
        n_checks++;
        if (saw_rdy != 0) begin
            n_fail++; $display("FAIL mid_reset_no_ready: %0d ready cycles, expected 0", saw_rdy);
        end
        check_all_zero("post_reset_state");
        txn(12'h0AC, 4'b0000, 32'h0, 32'hFEED_0042, 2, "after_reset");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_idle_noise();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
